// File: rtl/alu_pkg.sv
// Shared ALU function-select encodings, status bit positions and the
// multiply sequencer state type.
package alu_pkg;

  localparam logic [4:0] FS_AND  = 5'b00000;
  localparam logic [4:0] FS_OR   = 5'b00100;
  localparam logic [4:0] FS_ADD  = 5'b01000;
  localparam logic [4:0] FS_XOR  = 5'b01100;
  localparam logic [4:0] FS_SHL  = 5'b10000;
  localparam logic [4:0] FS_SHR  = 5'b10100;
  localparam logic [4:0] FS_ZERO = 5'b11000;

  localparam int Z_IDX = 0;
  localparam int N_IDX = 1;
  localparam int C_IDX = 2;
  localparam int V_IDX = 3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    TEST = 3'd1,
    ADD  = 3'd2,
    SHL  = 3'd3,
    SHR  = 3'd4,
    DONE = 3'd5
  } mul_state_e;

endpackage

// File: rtl/mul_sequencer.sv
// Shift-and-add multiplier controller: borrows the shared execute-stage ALU
// to build the low WIDTH bits of op_a*op_b, stalling the pipe through busy.
module mul_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [4:0]       alu_fs,
  output logic             alu_c0,
  input  logic [WIDTH-1:0] alu_f,
  input  logic [3:0]       alu_status
);

  mul_state_e       state_q, state_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;

  // ALU controls are a pure decode of the state; the ALU answer is folded
  // back into the register the state owns at the edge that ends it.
  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    m_d      = m_q;
    q_d      = q_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    alu_a    = '0;
    alu_b    = '0;
    alu_fs   = FS_ZERO;
    case (state_q)
      IDLE: begin
        if (start) begin
          p_d     = '0;
          m_d     = op_a;
          q_d     = op_b;
          cnt_d   = '0;
          state_d = TEST;
        end
      end
      TEST: begin
        if (q_q == '0) begin
          result_d = p_q;
          state_d  = DONE;
        end else if (q_q[0]) begin
          state_d = ADD;
        end else begin
          state_d = SHL;
        end
      end
      ADD: begin
        alu_a   = p_q;
        alu_b   = m_q;
        alu_fs  = FS_ADD;
        p_d     = alu_f;
        state_d = SHL;
      end
      SHL: begin
        alu_a   = m_q;
        alu_b   = WIDTH'(1);
        alu_fs  = FS_SHL;
        m_d     = alu_f;
        state_d = SHR;
      end
      SHR: begin
        alu_a   = q_q;
        alu_b   = WIDTH'(1);
        alu_fs  = FS_SHR;
        q_d     = alu_f;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = TEST;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      p_q      <= '0;
      m_q      <= '0;
      q_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      m_q      <= m_d;
      q_q      <= q_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign alu_c0 = 1'b0;

  // Q empties after at most WIDTH shifts, so the counter can never pass WIDTH.
  assert property (@(posedge clock) disable iff (reset) cnt_q <= CNT_W'(WIDTH));

  // With the zero function selected the ALU must report a clean zero result.
  assert property (@(posedge clock) disable iff (reset)
    (alu_fs == FS_ZERO) |-> (alu_status == 4'b0001));

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: a behavioural ALU drives alu_f, and a
// cycle-level product/latency model is compared against the DUT every cycle.
module tb_mul_sequencer;
  import alu_pkg::*;

  logic        clock;
  logic        reset;
  logic        start;
  logic [63:0] opA, opB;
  logic        busy, done, aluC0;
  logic [63:0] result, aluA, aluB, aluF;
  logic [4:0]  aluFs;
  logic [3:0]  aluStatus;

  int nChecks = 0;
  int nFails  = 0;

  mul_sequencer #(.WIDTH(64), .CNT_W(7)) dut (
    .clock(clock), .reset(reset), .start(start), .op_a(opA), .op_b(opB),
    .busy(busy), .done(done), .result(result),
    .alu_a(aluA), .alu_b(aluB), .alu_fs(aluFs), .alu_c0(aluC0),
    .alu_f(aluF), .alu_status(aluStatus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural execute-stage ALU.
  logic [63:0] aluA2, aluB2;
  logic [64:0] aluSum;
  always_comb begin
    aluA2  = aluFs[1] ? ~aluA : aluA;
    aluB2  = aluFs[0] ? ~aluB : aluB;
    aluSum = {1'b0, aluA2} + {1'b0, aluB2} + {64'b0, aluC0};
    case (aluFs[4:2])
      3'd0:    aluF = aluA2 & aluB2;
      3'd1:    aluF = aluA2 | aluB2;
      3'd2:    aluF = aluSum[63:0];
      3'd3:    aluF = aluA2 ^ aluB2;
      3'd4:    aluF = aluA2 << aluB2[5:0];
      3'd5:    aluF = aluA2 >> aluB2[5:0];
      default: aluF = 64'd0;
    endcase
    aluStatus[Z_IDX] = (aluF == 64'd0);
    aluStatus[N_IDX] = aluF[63];
    aluStatus[C_IDX] = (aluFs[4:2] == 3'd2) ? aluSum[64] : 1'b0;
    aluStatus[V_IDX] = (aluFs[4:2] == 3'd2) ?
                       ((aluA2[63] == aluB2[63]) && (aluF[63] != aluA2[63])) : 1'b0;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Cycles from acceptance to done: one TEST per iteration plus SHL/SHR,
  // ADD only for set bits, up to the top set bit; then final TEST and DONE.
  function automatic int expLatency(input logic [63:0] b);
    int lat = 2;
    int top = -1;
    for (int i = 0; i < 64; i++) if (b[i]) top = i;
    for (int i = 0; i <= top; i++) lat += 3 + int'(b[i]);
    return lat;
  endfunction

  // Model: cycle k ends at edge k; an op accepted at edge k is busy k+1..k+L.
  int          cyc = 0;
  bit          mActive = 1'b0;
  int          mAcceptK = 0;
  int          mDoneCyc = 0;
  logic [63:0] mPending = '0;
  logic [63:0] mRes = '0;
  always @(posedge clock) begin
    int  prev;
    bit  prevIdle;
    prev     = cyc;
    prevIdle = !mActive;
    cyc      = prev + 1;
    if (reset) begin
      mActive = 1'b0;
      mRes    = '0;
    end else begin
      if (mActive && prev == mDoneCyc) mActive = 1'b0;
      if (prevIdle && start) begin
        mActive  = 1'b1;
        mAcceptK = prev;
        mDoneCyc = prev + expLatency(opB);
        mPending = opA * opB;
      end
      if (mActive && cyc == mDoneCyc) mRes = mPending;
    end
  end

  int         doneCount = 0;
  bit         traceOn = 1'b0;
  logic [4:0] fsTrace[$];
  initial begin
    @(posedge clock);
    forever begin
      @(negedge clock);
      checkOutput("busy", busy, mActive);
      checkOutput("done", done, mActive && (cyc == mDoneCyc));
      checkOutput("result", result, mRes);
      checkOutput("alu_c0", aluC0, 1'b0);
      if (!mActive) begin
        checkOutput("idle alu_fs", aluFs, FS_ZERO);
        checkOutput("idle alu_a", aluA, 64'd0);
        checkOutput("idle alu_b", aluB, 64'd0);
      end
      if (done) doneCount++;
      if (traceOn && aluFs != FS_ZERO) fsTrace.push_back(aluFs);
    end
  end

  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b);
    @(negedge clock);
    #1;
    opA   = a;
    opB   = b;
    start = 1'b1;
    @(negedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input int maxCyc, output int doneAt);
    doneAt = -1;
    for (int i = 0; i < maxCyc; i++) begin
      @(negedge clock);
      #1;
      if (done === 1'b1) begin
        doneAt = cyc;
        break;
      end
    end
    checkOutput("done seen before timeout", (doneAt >= 0), 1'b1);
  endtask

  initial begin
    int doneAt;
    int firstDone;
    int dc;
    reset = 1'b1;
    start = 1'b0;
    opA   = '0;
    opB   = '0;
    repeat (2) @(negedge clock);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset alu_fs", aluFs, 5'b11000);
    #1 reset = 1'b0;

    applyStimulus(64'd6, 64'd0);
    waitDone(20, doneAt);
    checkOutput("op_b=0 latency", doneAt - mAcceptK, 2);
    checkOutput("op_b=0 result", result, 64'd0);

    traceOn = 1'b1;
    applyStimulus(64'd6, 64'd7);
    waitDone(40, doneAt);
    traceOn = 1'b0;
    checkOutput("6x7 latency", doneAt - mAcceptK, 14);
    checkOutput("6x7 result", result, 64'd42);
    checkOutput("6x7 fs trace length", fsTrace.size(), 9);
    for (int i = 0; i < fsTrace.size() && i < 9; i++) begin
      checkOutput("6x7 fs trace entry", fsTrace[i],
                  (i % 3 == 0) ? 5'b01000 : ((i % 3 == 1) ? 5'b10000 : 5'b10100));
    end

    applyStimulus(64'd5, 64'd7);
    repeat (3) @(negedge clock);
    #1 reset = 1'b1;
    dc = doneCount;
    @(negedge clock);
    checkOutput("mid-op reset busy", busy, 1'b0);
    checkOutput("mid-op reset result", result, 64'd0);
    #1 reset = 1'b0;
    repeat (20) @(negedge clock);
    checkOutput("no done after abort", doneCount, dc);

    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'd3);
    waitDone(40, doneAt);
    checkOutput("-1x3 result", result, 64'hFFFF_FFFF_FFFF_FFFD);
    checkOutput("-1x3 latency", doneAt - mAcceptK, 10);

    applyStimulus(64'h1_0000_0000, 64'h1_0000_0000);
    waitDone(200, doneAt);
    checkOutput("2^32 squared wraps", result, 64'd0);

    applyStimulus(64'd5, 64'hFFFF_FFFF_FFFF_FFFF);
    waitDone(300, doneAt);
    checkOutput("all-ones latency", doneAt - mAcceptK, 258);
    checkOutput("5 x all-ones result", result, 64'hFFFF_FFFF_FFFF_FFFB);

    // start held, re-pulsed while busy, then operands swapped at DONE.
    @(negedge clock);
    #1;
    dc    = doneCount;
    opA   = 64'd6;
    opB   = 64'd7;
    start = 1'b1;
    repeat (4) @(negedge clock);
    #1 start = 1'b0;
    @(negedge clock);
    #1 start = 1'b1;
    waitDone(40, firstDone);
    checkOutput("held start result", result, 64'd42);
    opA = 64'd2;
    opB = 64'd3;
    @(negedge clock);
    checkOutput("idle after done", busy, 1'b0);
    checkOutput("result held until accept", result, 64'd42);
    @(negedge clock);
    #1 start = 1'b0;
    checkOutput("re-accept cycle", mAcceptK, firstDone + 1);
    waitDone(40, doneAt);
    checkOutput("second op result", result, 64'd6);
    checkOutput("exactly two ops ran", doneCount - dc, 2);

    repeat (3) @(negedge clock);
    $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
